aes_encipher_lanes: RTL and testbench
=====================================

# aes_encipher_lanes

Parametrised iterative AES encipher datapath supporting 128-, 192- and 256-bit keys. SubBytes processes 1, 2 or 4 32-bit words per cycle, selected at elaboration, trading external S-box instances against latency. Blocks enter and leave on valid/ready streams, and a separate output holding register lets the engine start the next block while the previous result waits on backpressure. It sits between the block/mode controller and the shared key memory and S-box bank, which the integrator instantiates `SBOX_LANES` times.

## Interface
- `SBOX_LANES`, default 4: S-box words processed per cycle; legal values 1, 2, 4; any other value is an elaboration error.
- `clk`  in  1  clock, all state updates on rising edge.
- `reset_n`  in  1  one clock; reset is asynchronous and active-low.
- `keylen`  in  2  key length: 0 = 128 (Nr=10), 1 = 192 (Nr=12), 2 or 3 = 256 (Nr=14); sampled only on block acceptance.
- `in_valid`  in  1  input block valid.
- `in_ready`  out  1  engine can accept a block (state IDLE).
- `in_block`  in  128  plaintext; w0 = [127:96].
- `round`  out  4  round index for the key memory.
- `round_key`  in  128  round key for `round`, combinational same cycle.
- `sboxw`  out  32*SBOX_LANES  words to S-box; lane i = bits [32i+31:32i].
- `new_sboxw`  in  32*SBOX_LANES  S-box results, combinational same cycle, same lane mapping.
- `out_valid`  out  1  `out_block` holds a result.
- `out_ready`  in  1  consumer takes result.
- `out_block`  out  128  ciphertext.
- `busy`  out  1  state not IDLE.

## Operation
- Definitions: S = 4/SBOX_LANES. Registers: state block (128), round_ctr (4), sword_ctr (2), keylen_reg (2), FSM, out_block_reg, out_valid_reg.
- IDLE: `round`=0; `in_ready`=1. On `in_valid`: state block <= `in_block` ^ `round_key` (round 0 key); keylen_reg <= `keylen`; round_ctr <= 1; sword_ctr <= 0; go SBOX.
- SBOX: lane i drives word index sword_ctr*SBOX_LANES+i of the state block (word 0 = [127:96]). Each result is written back to the same word. sword_ctr increments; on sword_ctr == S-1 it resets to 0 and the FSM goes to MAIN. For S=1 this is a single cycle.
- MAIN, round_ctr < Nr: block <= MixColumns(ShiftRows(block)) ^ `round_key`; round_ctr++; go SBOX.
- MAIN, round_ctr == Nr (final): result = ShiftRows(block) ^ `round_key`.
  - If the output slot is free (!out_valid_reg or `out_ready`): out_block_reg <= result; out_valid_reg <= 1; round_ctr <= 0; go IDLE.
  - Otherwise the FSM stalls in MAIN with all registers held and `round` held at Nr.
- Output slot: `out_ready` while `out_valid` clears out_valid_reg, unless it is reloaded in the same cycle, in which case out_valid_reg stays 1 with the new data.
- `sboxw` = 0 outside SBOX. GF arithmetic and ShiftRows follow FIPS-197; xtime reduction polynomial 0x1b.
- Reset values: FSM IDLE, `in_ready`=1, `busy`=0, `round`=0, `sboxw`=0, `out_valid`=0, `out_block`=0, all internal registers 0.
- Reset mid-operation: the in-flight block and any pending output are discarded; no partial `out_valid` is produced.

## Timing
- Acceptance edge counts as cycle 0. `out_valid` rises Nr*(S+1) cycles later with no backpressure:
  - 128-bit key: 50 / 30 / 20 cycles for 1 / 2 / 4 lanes.
  - 192-bit key: 60 / 36 / 24 cycles.
  - 256-bit key: 70 / 42 / 28 cycles.
- `in_ready` reasserts the cycle after the final update.
- Maximum throughput is one block per Nr*(S+1)+1 cycles, because the IDLE acceptance cycle is not overlapped with the final update.
- `round` changes only on a MAIN update or on acceptance. It is stable through each SBOX phase and through stalls.
- `keylen` changes mid-block have no effect.

## Test plan
- Test harness: the key memory model returns FIPS-197 expanded keys indexed by `round`, and `SBOX_LANES` S-box models are attached.
- FIPS-197 C.1, for each `SBOX_LANES` value: key 000102…0f, pt 00112233445566778899aabbccddeeff -> out 69c4e0d86a7b0430d8cdb78070b4c55a, out_valid at cycle 50/30/20.
- FIPS-197 C.2/C.3, same pt: 192-bit key 000102…17 -> dda97ca4864cdfe06eaf70a0ec0d7191; 256-bit key 000102…1f -> 8ea2b7ca516745bfeafc49904b496089, latency 70 with SBOX_LANES=1.
- Back-to-back with in_valid held high and out_ready=1: two C.1 blocks -> both correct, second accepted exactly one cycle after the first final update.
- Backpressure with out_ready=0: two blocks -> the first result is held stable, the second stalls in MAIN with round=10. Raising out_ready for 1 cycle -> the second result loads and out_valid stays 1.
- Reset pulse at cycle 15 of a block -> out_valid=0, in_ready=1, round=0; a fresh C.1 block afterwards is correct.
- keylen toggled between 0 and 2 mid-block (accepted with 0) -> 128-bit result, latency unchanged.

Source files
------------

// File: rtl/aes_encipher_lanes.sv
`default_nettype none
// ============================================================================
//  Module   : aes_encipher_lanes
//  Purpose  : Iterative AES encipher datapath (128/192/256-bit keys) with a
//             configurable number of external S-box lanes and a decoupled
//             output holding register.
//  Revision : 1.0  initial release
// ============================================================================
module aes_encipher_lanes #(
    parameter int SBOX_LANES = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [1:0]                keylen,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [127:0]              in_block,
    output logic [3:0]                round,
    input  logic [127:0]              round_key,
    output logic [32*SBOX_LANES-1:0]  sboxw,
    input  logic [32*SBOX_LANES-1:0]  new_sboxw,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [127:0]              out_block,
    output logic                      busy
);

    // Only lane counts that divide the four state words evenly are usable.
    generate
        if (SBOX_LANES != 1 && SBOX_LANES != 2 && SBOX_LANES != 4) begin : g_bad_lanes
            $error("aes_encipher_lanes: SBOX_LANES must be 1, 2 or 4");
        end
    endgenerate

    // Number of SubBytes cycles per round and the last sword_ctr value.
    localparam int         c_S          = 4 / SBOX_LANES;
    localparam logic [1:0] c_SWORD_LAST = 2'(c_S - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SBOX = 2'd1,
        ST_MAIN = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // GF(2^8) helpers and the linear round layers
    // ------------------------------------------------------------------
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_word(input logic [31:0] w);
        logic [7:0] b0, b1, b2, b3;
        logic [7:0] m0, m1, m2, m3;
        b0 = w[31:24];
        b1 = w[23:16];
        b2 = w[15:8];
        b3 = w[7:0];
        m0 = xtime(b0) ^ xtime(b1) ^ b1 ^ b2 ^ b3;
        m1 = b0 ^ xtime(b1) ^ xtime(b2) ^ b2 ^ b3;
        m2 = b0 ^ b1 ^ xtime(b2) ^ xtime(b3) ^ b3;
        m3 = xtime(b0) ^ b0 ^ b1 ^ b2 ^ xtime(b3);
        return {m0, m1, m2, m3};
    endfunction

    // Column c occupies [127-32c -: 32]; row r is byte r within that word.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c + r) % 4) + r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            o[127 - 32*c -: 32] = mix_word(s[127 - 32*c -: 32]);
        end
        return o;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t         r_state;
    state_t         w_state_next;
    logic [127:0]   r_block;
    logic [3:0]     r_round_ctr;
    logic [1:0]     r_sword_ctr;
    logic [1:0]     r_keylen;
    logic [127:0]   r_out_block;
    logic           r_out_valid;

    logic [3:0]     w_nr;
    logic           w_slot_free;
    logic           w_accept;
    logic           w_sbox_step;
    logic           w_round_step;
    logic           w_final_load;
    logic [127:0]   w_block_sub;
    logic [127:0]   w_block_round;
    logic [127:0]   w_block_final;
    logic [32*SBOX_LANES-1:0] w_sboxw;

    // Round count follows the key length latched at acceptance.
    always_comb begin
        w_nr = 4'd14;
        case (r_keylen)
            2'd0:    w_nr = 4'd10;
            2'd1:    w_nr = 4'd12;
            default: w_nr = 4'd14;
        endcase
    end

    assign w_slot_free   = !r_out_valid || out_ready;
    assign w_block_round = mix_columns(shift_rows(r_block)) ^ round_key;
    assign w_block_final = shift_rows(r_block) ^ round_key;

    // Route the selected state words to the S-box lanes and merge results back.
    always_comb begin
        int k;
        k           = 0;
        w_sboxw     = '0;
        w_block_sub = r_block;
        for (int i = 0; i < SBOX_LANES; i++) begin
            k = (int'(r_sword_ctr) * SBOX_LANES + i) & 3;
            if (r_state == ST_SBOX) begin
                w_sboxw[32*i +: 32]            = r_block[(3 - k)*32 +: 32];
                w_block_sub[(3 - k)*32 +: 32] = new_sboxw[32*i +: 32];
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state and datapath step selection.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_sbox_step  = 1'b0;
        w_round_step = 1'b0;
        w_final_load = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = ST_SBOX;
                end
            end
            ST_SBOX: begin
                w_sbox_step = 1'b1;
                if (r_sword_ctr == c_SWORD_LAST) begin
                    w_state_next = ST_MAIN;
                end
            end
            ST_MAIN: begin
                if (r_round_ctr == w_nr) begin
                    // Final round waits here until the output slot can take it.
                    if (w_slot_free) begin
                        w_final_load = 1'b1;
                        w_state_next = ST_IDLE;
                    end
                end else begin
                    w_round_step = 1'b1;
                    w_state_next = ST_SBOX;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Block, counters and latched key length.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_block     <= '0;
            r_round_ctr <= '0;
            r_sword_ctr <= '0;
            r_keylen    <= '0;
        end else if (w_accept) begin
            r_block     <= in_block ^ round_key;
            r_keylen    <= keylen;
            r_round_ctr <= 4'd1;
            r_sword_ctr <= 2'd0;
        end else if (w_sbox_step) begin
            r_block     <= w_block_sub;
            r_sword_ctr <= (r_sword_ctr == c_SWORD_LAST) ? 2'd0 : r_sword_ctr + 2'd1;
        end else if (w_round_step) begin
            r_block     <= w_block_round;
            r_round_ctr <= r_round_ctr + 4'd1;
        end else if (w_final_load) begin
            r_round_ctr <= 4'd0;
        end
    end

    // Output holding slot: reload wins over a same-cycle consume.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out_block <= '0;
            r_out_valid <= 1'b0;
        end else if (w_final_load) begin
            r_out_block <= w_block_final;
            r_out_valid <= 1'b1;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign busy      = (r_state != ST_IDLE);
    assign round     = r_round_ctr;
    assign sboxw     = w_sboxw;
    assign out_valid = r_out_valid;
    assign out_block = r_out_block;

endmodule
`default_nettype wire

// File: tb/tb_aes_encipher_lanes.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_aes_encipher_lanes
//  Purpose  : Directed FIPS-197 bench for aes_encipher_lanes, one instance
//             per lane count (1, 2, 4) with key memory and S-box models.
//  Revision : 1.0  initial release
// ============================================================================
module tb_aes_encipher_lanes;

    localparam logic [127:0] c_PT      = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] c_CT128   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] c_CT192   = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] c_CT256   = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [255:0] c_KEY128  = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] c_KEY192  = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
    localparam logic [255:0] c_KEY256  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [255:0] c_KEYB    = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [127:0] c_PTB     = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] c_CTB     = 128'h3925841d02dc09fbdc118597196a0b32;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [1:0]   keylen;
    logic [2:0]   iv;
    logic [127:0] in_block;
    logic         out_ready;
    logic [2:0]   ir, ov, bsy;
    logic [3:0]   rnd [3];
    logic [127:0] ob  [3];
    logic [127:0] rk  [16];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in; b = b_in; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction

    // S-box from the GF inverse (x^254) followed by the FIPS-197 affine map.
    function automatic logic [7:0] sbox_b(input logic [7:0] x);
        logic [7:0] s, p;
        s = x; p = 8'h01;
        for (int i = 0; i < 7; i++) begin
            s = gmul(s, s);
            p = gmul(p, s);
        end
        return p ^ {p[6:0], p[7]} ^ {p[5:0], p[7:6]} ^ {p[4:0], p[7:5]} ^ {p[3:0], p[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sbox_b(w[31:24]), sbox_b(w[23:16]), sbox_b(w[15:8]), sbox_b(w[7:0])};
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int LN = 1 << g;
        logic [32*LN-1:0] sbw;
        logic [32*LN-1:0] nsb;
        logic [127:0]     rkey;
        assign rkey = rk[rnd[g]];
        for (genvar l = 0; l < LN; l++) begin : g_sb
            assign nsb[32*l +: 32] = subw(sbw[32*l +: 32]);
        end
        aes_encipher_lanes #(.SBOX_LANES(LN)) u_dut (
            .clk       (clk),
            .reset_n   (reset_n),
            .keylen    (keylen),
            .in_valid  (iv[g]),
            .in_ready  (ir[g]),
            .in_block  (in_block),
            .round     (rnd[g]),
            .round_key (rkey),
            .sboxw     (sbw),
            .new_sboxw (nsb),
            .out_valid (ov[g]),
            .out_ready (out_ready),
            .out_block (ob[g]),
            .busy      (bsy[g])
        );
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Key memory model: FIPS-197 key expansion into rk[0..Nr].
    task automatic load_key(input logic [255:0] key, input int nk);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        int          nr;
        nr = nk + 6;
        rc = 8'h01;
        for (int i = 0; i < 4*(nr + 1); i++) begin
            if (i < nk) begin
                w[i] = key[255 - 32*i -: 32];
            end else begin
                t = w[i-1];
                if (i % nk == 0) begin
                    t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                    rc = gmul(rc, 8'h02);
                end else if (nk > 6 && i % nk == 4) begin
                    t = subw(t);
                end
                w[i] = w[i-nk] ^ t;
            end
        end
        for (int r = 0; r < 16; r++) begin
            if (r <= nr) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
            else         rk[r] = '0;
        end
    endtask

    // Start one block on the masked instances; record first out_valid cycle.
    task automatic run_block(input logic [2:0] mask, input logic [127:0] pt,
                             input logic [1:0] kl, input bit toggle,
                             input logic [127:0] exp_ct,
                             input int lat0, input int lat1, input int lat2,
                             input string tag);
        int           seen    [3];
        int           exp_lat [3];
        logic [127:0] got     [3];
        exp_lat = '{lat0, lat1, lat2};
        for (int g = 0; g < 3; g++) begin
            seen[g] = -1;
            got[g]  = '0;
        end
        in_block = pt;
        keylen   = kl;
        iv       = mask;
        tick();
        iv = 3'b000;
        for (int n = 1; n <= 80; n++) begin
            if (toggle) keylen = (n % 2 == 1) ? 2'd2 : 2'd0;
            tick();
            for (int g = 0; g < 3; g++) begin
                if (mask[g] && seen[g] < 0 && ov[g]) begin
                    seen[g] = n;
                    got[g]  = ob[g];
                end
            end
        end
        keylen = 2'd0;
        for (int g = 0; g < 3; g++) begin
            if (mask[g]) begin
                check($sformatf("%s_lat_l%0d", tag, 1 << g), 128'(seen[g]), 128'(exp_lat[g]));
                check($sformatf("%s_ct_l%0d", tag, 1 << g), got[g], exp_ct);
            end
        end
    endtask

    initial begin
        int first, second;
        logic prev;
        reset_n   = 1'b0;
        keylen    = 2'd0;
        iv        = 3'b000;
        in_block  = '0;
        out_ready = 1'b1;
        load_key(c_KEY128, 4);
        tick();
        tick();

        // Reset state
        for (int g = 0; g < 3; g++) begin
            check($sformatf("rst_flags_l%0d", 1 << g),
                  {124'h0, ov[g], ir[g], bsy[g], 1'b0}, {124'h0, 4'b0100});
            check($sformatf("rst_round_l%0d", 1 << g), {124'h0, rnd[g]}, '0);
            check($sformatf("rst_out_l%0d", 1 << g), ob[g], '0);
        end
        check("rst_sboxw_l4", g_dut[2].sbw, '0);
        reset_n = 1'b1;
        tick();

        // FIPS-197 C.1 / C.2 / C.3 on all lane counts
        run_block(3'b111, c_PT, 2'd0, 1'b0, c_CT128, 50, 30, 20, "c1");
        load_key(c_KEY192, 6);
        run_block(3'b111, c_PT, 2'd1, 1'b0, c_CT192, 60, 36, 24, "c2");
        load_key(c_KEY256, 8);
        run_block(3'b111, c_PT, 2'd2, 1'b0, c_CT256, 70, 42, 28, "c3");
        load_key(c_KEY128, 4);

        // Back-to-back on the 4-lane instance with in_valid held high
        first  = -1;
        second = -1;
        prev   = 1'b0;
        in_block  = c_PT;
        keylen    = 2'd0;
        out_ready = 1'b1;
        iv        = 3'b100;
        tick();
        for (int n = 1; n <= 60; n++) begin
            tick();
            if (n == 20) check("b2b_ready_after_final", {126'h0, ov[2], ir[2]}, 128'h3);
            if (n == 21) begin
                check("b2b_second_accepted", {126'h0, ir[2], bsy[2]}, 128'h1);
                iv = 3'b000;
            end
            if (ov[2] && !prev) begin
                if (first < 0) begin
                    first = n;
                    check("b2b_ct1", ob[2], c_CT128);
                end else if (second < 0) begin
                    second = n;
                    check("b2b_ct2", ob[2], c_CT128);
                end
            end
            prev = ov[2];
        end
        check("b2b_lat1", 128'(first), 128'd20);
        check("b2b_lat2", 128'(second), 128'd41);

        // Backpressure: first result held, second stalls at the final round
        load_key(c_KEYB, 4);
        in_block  = c_PTB;
        out_ready = 1'b0;
        iv        = 3'b100;
        tick();
        iv = 3'b000;
        repeat (20) tick();
        check("bp_first_valid", {127'h0, ov[2]}, 128'h1);
        check("bp_first_ct", ob[2], c_CTB);
        check("bp_ready_for_second", {127'h0, ir[2]}, 128'h1);
        load_key(c_KEY128, 4);
        in_block = c_PT;
        iv       = 3'b100;
        tick();
        iv = 3'b000;
        repeat (25) tick();
        check("bp_stall_round", {124'h0, rnd[2]}, 128'd10);
        check("bp_stall_flags", {125'h0, ov[2], ir[2], bsy[2]}, 128'h5);
        check("bp_first_held", ob[2], c_CTB);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_reload_valid", {127'h0, ov[2]}, 128'h1);
        check("bp_second_ct", ob[2], c_CT128);
        check("bp_idle_after", {124'h0, rnd[2]}, 128'h0);
        out_ready = 1'b1;
        tick();
        check("bp_drained", {127'h0, ov[2]}, 128'h0);

        // Reset in the middle of a block
        in_block = c_PT;
        iv       = 3'b100;
        tick();
        iv = 3'b000;
        repeat (15) tick();
        reset_n = 1'b0;
        #1;
        check("midrst_flags", {125'h0, ov[2], ir[2], bsy[2]}, 128'h2);
        check("midrst_round", {124'h0, rnd[2]}, 128'h0);
        tick();
        reset_n = 1'b1;
        tick();
        check("midrst_no_output", {127'h0, ov[2]}, 128'h0);
        run_block(3'b100, c_PT, 2'd0, 1'b0, c_CT128, 0, 0, 20, "midrst_fresh");

        // keylen toggling after acceptance must not change the block
        run_block(3'b111, c_PT, 2'd0, 1'b1, c_CT128, 50, 30, 20, "kl_tog");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
